// File: rtl/ram1_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the arbiter and the RAM1/UART port.
// The slave modport is the arbiter's view; the master modport is the requesters' and port's view.
interface ram1_arbiter_if;
  logic        if_req_i;
  logic [17:0] if_addr_i;
  logic        if_ack_o;
  logic [15:0] if_rdata_o;

  logic        mem_req_i;
  logic        mem_we_i;
  logic [17:0] mem_addr_i;
  logic [15:0] mem_wdata_i;
  logic        mem_ack_o;
  logic [15:0] mem_rdata_o;

  logic        stall_o;

  logic        is_RAM1_o;
  logic        is_UART_o;
  logic [17:0] addr_o;
  logic [15:0] data_o;
  logic        isread_o;
  logic        iswrite_o;
  logic [15:0] ram1res_i;
  logic        data_ready_i;
  logic        tbre_i;
  logic        tsre_i;

  modport slave (
    input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
    input  ram1res_i, data_ready_i, tbre_i, tsre_i,
    output if_ack_o, if_rdata_o, mem_ack_o, mem_rdata_o, stall_o,
    output is_RAM1_o, is_UART_o, addr_o, data_o, isread_o, iswrite_o
  );

  modport master (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
    output ram1res_i, data_ready_i, tbre_i, tsre_i,
    input  if_ack_o, if_rdata_o, mem_ack_o, mem_rdata_o, stall_o,
    input  is_RAM1_o, is_UART_o, addr_o, data_o, isread_o, iswrite_o
  );
endinterface

// File: rtl/ram1_arbiter.sv
// RAM1/UART port arbiter: shares the port between instruction fetch (read-only) and
// the data memory stage, sequencing each access as SETUP -> STROBE -> DONE.
// Optional macro RAM1_ARB_UART_WAIT_EN inserts a WAIT state before STROBE for
// UART data-register accesses until the UART status reports ready.
module ram1_arbiter #(
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
  parameter int unsigned MEM_BURST_MAX  = 4
) (
  input logic           clk,
  input logic           rst,
  ram1_arbiter_if.slave bus
);

  localparam logic [3:0] BurstMax = 4'(MEM_BURST_MAX);

  typedef enum logic [2:0] {StIdle, StSetup, StWait, StStrobe, StDone} state_e;

  state_e      state_q, state_d;
  logic        gnt_mem_q, gnt_mem_d;
  logic        we_q, we_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  burst_q, burst_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] mem_rdata_q, mem_rdata_d;

  logic is_uart, is_stat, busy;

  assign is_stat = (addr_q[15:0] == UART_STAT_ADDR);
  assign is_uart = (addr_q[15:0] == UART_DATA_ADDR) || is_stat;
  assign busy    = (state_q != StIdle);

`ifdef RAM1_ARB_UART_WAIT_EN
  logic is_data, uart_ready;
  assign is_data    = (addr_q[15:0] == UART_DATA_ADDR);
  assign uart_ready = we_q ? (bus.tbre_i & bus.tsre_i) : bus.data_ready_i;
`else
  logic unused_uart_status;
  assign unused_uart_status = bus.data_ready_i ^ bus.tbre_i ^ bus.tsre_i;
`endif

  // Next-state: arbitration and request latching in IDLE, fixed access sequence otherwise.
  always_comb begin
    state_d     = state_q;
    gnt_mem_d   = gnt_mem_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    burst_d     = burst_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      StIdle: begin
        // MEM has priority until it has used its burst allowance while IF waits.
        if (bus.mem_req_i && !((burst_q == BurstMax) && bus.if_req_i)) begin
          gnt_mem_d = 1'b1;
          we_d      = bus.mem_we_i;
          addr_d    = bus.mem_addr_i;
          data_d    = bus.mem_wdata_i;
          burst_d   = bus.if_req_i ? burst_q + 4'd1 : 4'd0;
          state_d   = StSetup;
        end else if (bus.if_req_i) begin
          gnt_mem_d = 1'b0;
          we_d      = 1'b0;
          addr_d    = bus.if_addr_i;
          data_d    = 16'h0;
          burst_d   = 4'd0;
          state_d   = StSetup;
        end
      end
      StSetup: begin
`ifdef RAM1_ARB_UART_WAIT_EN
        state_d = is_data ? StWait : StStrobe;
`else
        state_d = StStrobe;
`endif
      end
      StWait: begin
`ifdef RAM1_ARB_UART_WAIT_EN
        if (uart_ready) state_d = StStrobe;
`else
        state_d = StStrobe;
`endif
      end
      StStrobe: begin
        if (!we_q) begin
          if (gnt_mem_q) mem_rdata_d = bus.ram1res_i;
          else           if_rdata_d  = bus.ram1res_i;
        end
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and latched-access registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_mem_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 18'h0;
      data_q      <= 16'h0;
      burst_q     <= 4'd0;
      if_rdata_q  <= 16'h0;
      mem_rdata_q <= 16'h0;
    end else begin
      state_q     <= state_d;
      gnt_mem_q   <= gnt_mem_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      burst_q     <= burst_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus.is_RAM1_o   = busy && !is_uart;
  assign bus.is_UART_o   = busy && is_uart;
  assign bus.addr_o      = addr_q;
  assign bus.data_o      = data_q;
  assign bus.isread_o    = (state_q == StStrobe) && !we_q;
  // The UART status register is read-only, so writes to it complete without a strobe.
  assign bus.iswrite_o   = (state_q == StStrobe) && we_q && !is_stat;
  assign bus.if_ack_o    = (state_q == StDone) && !gnt_mem_q;
  assign bus.mem_ack_o   = (state_q == StDone) && gnt_mem_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.mem_rdata_o = mem_rdata_q;
  assign bus.stall_o     = (bus.if_req_i & ~bus.if_ack_o) | (bus.mem_req_i & ~bus.mem_ack_o);

endmodule

// File: tb/tb_ram1_arbiter.sv
// Self-checking bench for ram1_arbiter: transaction-schedule model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_ram1_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ram1_arbiter_if bus ();

  ram1_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam int BurstMax = 4;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: an access granted in cycle g shows setup in g+1, strobe in g+2, ack in g+3
  // (UART data accesses with the wait feature strobe the cycle after readiness is seen).
  bit          m_valid = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_mem, m_we;
  logic [17:0] m_addr  = '0;
  logic [15:0] m_data  = '0;
  logic [15:0] m_if_rd = '0, m_mem_rd = '0;
  int          m_burst = 0;
  int          m_grant, m_strobe, m_ack;

  always @(negedge clk) begin : model
    bit uart, strobe_now, ack_now, e_stall, mem_wins, ready;
    uart       = m_busy && (m_addr[15:0] == 16'hBF00 || m_addr[15:0] == 16'hBF01);
    strobe_now = m_busy && (cyc == m_strobe);
    ack_now    = m_busy && (cyc == m_ack);
    e_stall    = (bus.if_req_i && !(ack_now && !m_mem)) || (bus.mem_req_i && !(ack_now && m_mem));
    if (m_valid) begin
      chk("m_is_ram1", bus.is_RAM1_o, m_busy && !uart);
      chk("m_is_uart", bus.is_UART_o, uart);
      chk("m_addr", bus.addr_o, m_addr);
      chk("m_data", bus.data_o, m_data);
      chk("m_isread", bus.isread_o, strobe_now && !m_we);
      chk("m_iswrite", bus.iswrite_o, strobe_now && m_we && m_addr[15:0] != 16'hBF01);
      chk("m_if_ack", bus.if_ack_o, ack_now && !m_mem);
      chk("m_mem_ack", bus.mem_ack_o, ack_now && m_mem);
      chk("m_if_rdata", bus.if_rdata_o, m_if_rd);
      chk("m_mem_rdata", bus.mem_rdata_o, m_mem_rd);
      chk("m_stall", bus.stall_o, e_stall);
    end
    if (rst) begin
      m_valid  = 1'b1;
      m_busy   = 1'b0;
      m_burst  = 0;
      m_addr   = '0;
      m_data   = '0;
      m_if_rd  = '0;
      m_mem_rd = '0;
    end else if (m_valid) begin
      if (m_busy) begin
        if (strobe_now && !m_we) begin
          if (m_mem) m_mem_rd = bus.ram1res_i;
          else       m_if_rd  = bus.ram1res_i;
        end
        ready = m_we ? (bus.tbre_i && bus.tsre_i) : bus.data_ready_i;
        if (m_strobe < 0 && cyc >= m_grant + 2 && ready) begin
          m_strobe = cyc + 1;
          m_ack    = cyc + 2;
        end
        if (ack_now) m_busy = 1'b0;
      end else begin
        mem_wins = bus.mem_req_i && !(m_burst == BurstMax && bus.if_req_i);
        if (mem_wins || bus.if_req_i) begin
          m_busy  = 1'b1;
          m_grant = cyc;
          m_mem   = mem_wins;
          if (mem_wins) begin
            m_we    = bus.mem_we_i;
            m_addr  = bus.mem_addr_i;
            m_data  = bus.mem_wdata_i;
            m_burst = bus.if_req_i ? m_burst + 1 : 0;
          end else begin
            m_we    = 1'b0;
            m_addr  = bus.if_addr_i;
            m_data  = '0;
            m_burst = 0;
          end
          m_strobe = cyc + 2;
          m_ack    = cyc + 3;
`ifdef RAM1_ARB_UART_WAIT_EN
          if (m_addr[15:0] == 16'hBF00) begin
            m_strobe = -1;
            m_ack    = -1;
          end
`endif
        end
      end
    end
    cyc++;
  end

  logic if_ack_seen = 1'b0, mem_ack_seen = 1'b0;
  always @(negedge clk) begin
    if_ack_seen  <= bus.if_ack_o;
    mem_ack_seen <= bus.mem_ack_o;
  end

  function automatic logic [17:0] rand_addr();
    logic [17:0] a;
    a = 18'($urandom);
    case ($urandom_range(0, 3))
      0: a[15:0] = 16'hBF00;
      1: a[15:0] = 16'hBF01;
      default: ;
    endcase
    return a;
  endfunction

  // One directed access; k counts cycles from the first IDLE cycle that sees the request.
  task automatic run_access(input bit is_mem, input bit we, input logic [17:0] a,
                            input logic [15:0] wd, output int ack_at, output int rd_cnt,
                            output int wr_cnt, output int stall_cnt, output logic [15:0] rdata,
                            output logic sel_uart, output logic sel_ram1,
                            output logic [15:0] data_seen, output logic [17:0] addr_seen);
    ack_at = -1; rd_cnt = 0; wr_cnt = 0; stall_cnt = 0; rdata = 'x;
    sel_uart = 'x; sel_ram1 = 'x; data_seen = 'x; addr_seen = 'x;
    if (is_mem) begin
      bus.mem_req_i = 1'b1; bus.mem_we_i = we; bus.mem_addr_i = a; bus.mem_wdata_i = wd;
    end else begin
      bus.if_req_i = 1'b1; bus.if_addr_i = a;
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.stall_o)   stall_cnt++;
      if (bus.isread_o)  rd_cnt++;
      if (bus.iswrite_o) wr_cnt++;
      if (k == 1) begin
        sel_uart = bus.is_UART_o; sel_ram1 = bus.is_RAM1_o;
        data_seen = bus.data_o; addr_seen = bus.addr_o;
      end
      if (is_mem ? bus.mem_ack_o : bus.if_ack_o) begin
        ack_at = k;
        rdata  = is_mem ? bus.mem_rdata_o : bus.if_rdata_o;
        break;
      end
    end
    @(posedge clk); #1;
    bus.if_req_i = 1'b0; bus.mem_req_i = 1'b0;
  endtask

  task automatic rand_step();
    bus.ram1res_i    = 16'($urandom);
    bus.data_ready_i = ($urandom_range(0, 2) == 0);
    bus.tbre_i       = ($urandom_range(0, 3) != 0);
    bus.tsre_i       = ($urandom_range(0, 3) != 0);
    rst              = ($urandom_range(0, 149) == 0);
    if (bus.if_req_i) begin
      if (if_ack_seen) begin
        bus.if_req_i  = ($urandom_range(0, 2) == 0);
        bus.if_addr_i = rand_addr();
      end
    end else if ($urandom_range(0, 2) == 0) begin
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = rand_addr();
    end
    if (bus.mem_req_i && !mem_ack_seen) begin
      // Late changes before grant are legal; whatever is present at grant is latched.
      if ($urandom_range(0, 7) == 0) begin
        bus.mem_addr_i  = rand_addr();
        bus.mem_wdata_i = 16'($urandom);
      end
    end else if (bus.mem_req_i ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 0)) begin
      bus.mem_req_i   = 1'b1;
      bus.mem_we_i    = 1'($urandom);
      bus.mem_addr_i  = rand_addr();
      bus.mem_wdata_i = 16'($urandom);
    end else begin
      bus.mem_req_i = 1'b0;
    end
  endtask

  int          ack_at, rd_cnt, wr_cnt, stall_cnt, n;
  logic [15:0] rdata, data_seen;
  logic [17:0] addr_seen;
  logic        sel_uart, sel_ram1;
  bit          order[10];
  int          ack_cyc[10];
  bit          exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    bus.if_req_i = 0; bus.if_addr_i = '0; bus.mem_req_i = 0; bus.mem_we_i = 0;
    bus.mem_addr_i = '0; bus.mem_wdata_i = '0; bus.ram1res_i = '0;
    bus.data_ready_i = 1; bus.tbre_i = 1; bus.tsre_i = 1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset.
    repeat (2) @(negedge clk);
    chk("reset_stall", bus.stall_o, 0);
    chk("reset_addr", bus.addr_o, 0);
    chk("reset_strobes", {bus.isread_o, bus.iswrite_o}, 0);
    chk("reset_acks", {bus.if_ack_o, bus.mem_ack_o}, 0);
    chk("reset_rdata", {bus.if_rdata_o, bus.mem_rdata_o}, 0);
    @(posedge clk); #1;

    // IF read from RAM1.
    bus.ram1res_i = 16'h1234;
    run_access(0, 0, 18'h00010, 16'h0, ack_at, rd_cnt, wr_cnt, stall_cnt, rdata,
               sel_uart, sel_ram1, data_seen, addr_seen);
    chk("if_ack_cycle", ack_at, 3);
    chk("if_isread_count", rd_cnt, 1);
    chk("if_iswrite_count", wr_cnt, 0);
    chk("if_stall_cycles", stall_cnt, 3);
    chk("if_is_ram1", sel_ram1, 1);
    chk("if_addr_o", addr_seen, 18'h00010);
    chk("if_rdata", rdata, 16'h1234);

    // MEM write to UART data, then to the read-only status register.
    run_access(1, 1, 18'h0BF00, 16'h0041, ack_at, rd_cnt, wr_cnt, stall_cnt, rdata,
               sel_uart, sel_ram1, data_seen, addr_seen);
    chk("uart_wr_ack_cycle", ack_at, 3);
    chk("uart_wr_is_uart", {sel_uart, sel_ram1}, 2'b10);
    chk("uart_wr_data_o", data_seen, 16'h0041);
    chk("uart_wr_iswrite_count", wr_cnt, 1);
    run_access(1, 1, 18'h0BF01, 16'h0042, ack_at, rd_cnt, wr_cnt, stall_cnt, rdata,
               sel_uart, sel_ram1, data_seen, addr_seen);
    chk("stat_wr_ack_cycle", ack_at, 3);
    chk("stat_wr_iswrite_count", wr_cnt, 0);
    chk("stat_wr_is_uart", sel_uart, 1);

    // Both requesters held: MEM gets four grants, then IF is forced in.
    bus.ram1res_i = 16'h5A5A;
    bus.if_req_i = 1; bus.if_addr_i = 18'h00200;
    bus.mem_req_i = 1; bus.mem_we_i = 0; bus.mem_addr_i = 18'h00300;
    n = 0;
    for (int k = 0; k < 60 && n < 10; k++) begin
      @(negedge clk);
      if (bus.mem_ack_o || bus.if_ack_o) begin
        order[n] = bus.mem_ack_o; ack_cyc[n] = k; n++;
      end
    end
    @(posedge clk); #1;
    bus.if_req_i = 0; bus.mem_req_i = 0;
    chk("burst_ack_count", n, 10);
    chk("burst_first_ack", ack_cyc[0], 3);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("burst_order_%0d", i), order[i], exp_order[i]);
      if (i > 0) chk($sformatf("burst_spacing_%0d", i), ack_cyc[i] - ack_cyc[i-1], 4);
    end

    // Reset during the strobe of a MEM read, then the held request completes.
    bus.ram1res_i = 16'hBEEF;
    bus.mem_req_i = 1; bus.mem_we_i = 0; bus.mem_addr_i = 18'h00123;
    @(negedge clk);
    @(negedge clk);
    chk("rst_setup_ram1", bus.is_RAM1_o, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_strobe_isread", bus.isread_o, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_no_ack", bus.mem_ack_o, 0);
    chk("rst_idle_selects", {bus.is_RAM1_o, bus.is_UART_o, bus.isread_o}, 0);
    chk("rst_rdata_clear", bus.mem_rdata_o, 0);
    ack_at = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.mem_ack_o) begin ack_at = k; rdata = bus.mem_rdata_o; break; end
    end
    chk("rst_retry_ack_cycle", ack_at, 3);
    chk("rst_retry_rdata", rdata, 16'hBEEF);
    @(posedge clk); #1 bus.mem_req_i = 0;

`ifdef RAM1_ARB_UART_WAIT_EN
    // UART read waits for data_ready.
    bus.data_ready_i = 0; bus.ram1res_i = 16'h0077;
    bus.mem_req_i = 1; bus.mem_we_i = 0; bus.mem_addr_i = 18'h0BF00;
    rd_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.isread_o) rd_cnt++;
    end
    chk("wait_no_isread", rd_cnt, 0);
    @(posedge clk); #1 bus.data_ready_i = 1;
    @(negedge clk);
    chk("wait_seen_no_isread", bus.isread_o, 0);
    @(negedge clk);
    chk("wait_isread_after_ready", bus.isread_o, 1);
    @(negedge clk);
    chk("wait_ack_after_strobe", bus.mem_ack_o, 1);
    chk("wait_rdata", bus.mem_rdata_o, 16'h0077);
    @(posedge clk); #1 bus.mem_req_i = 0;
`endif

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rand_step();
    end
    @(posedge clk); #1;
    rst = 1'b1; bus.if_req_i = 0; bus.mem_req_i = 0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
